// File: rtl/fifo_rd_pkg.sv
// Shared types and sizing helpers for the FIFO burst reader.
// State encoding, skid depth and the burst counter width function.
package fifo_rd_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } rd_state_e;

  localparam int unsigned SKID_DEPTH = 2;
  localparam int unsigned SKID_CNT_W = $clog2(SKID_DEPTH + 1);

  // Width of a counter that must hold 0..burst_len inclusive.
  function automatic int unsigned cnt_width(input int unsigned burst_len);
    return $clog2(burst_len + 1);
  endfunction

endpackage

// File: rtl/fifo_burst_reader_if.sv
// FIFO read-side and output stream signals of the burst reader.
// master is the reader's view; slave is the FIFO/downstream view.
interface fifo_burst_reader_if #(
  parameter int unsigned FIFO_WIDTH = 32,
  parameter int unsigned FIFO_PTR   = 4
);

  logic                  fifo_rden;
  logic [FIFO_WIDTH-1:0] fifo_rddata;
  logic                  fifo_empty;
  logic [FIFO_PTR:0]     fifo_data_avail;
  logic                  flush;
  logic                  m_valid;
  logic                  m_ready;
  logic [FIFO_WIDTH-1:0] m_data;
  logic                  m_last;
  logic                  burst_active;

  modport master (
    output fifo_rden,
    input  fifo_rddata,
    input  fifo_empty,
    input  fifo_data_avail,
    input  flush,
    output m_valid,
    input  m_ready,
    output m_data,
    output m_last,
    output burst_active
  );

  modport slave (
    input  fifo_rden,
    output fifo_rddata,
    output fifo_empty,
    output fifo_data_avail,
    output flush,
    input  m_valid,
    output m_ready,
    input  m_data,
    input  m_last,
    input  burst_active
  );

endinterface

// File: rtl/rd_skid_buf.sv
// Two-entry register FIFO that soaks up the FIFO read latency and output stalls.
// Head data and valid come straight from registers; synchronous active-high reset.
module rd_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_push,
  input  logic [WIDTH-1:0]      i_push_data,
  input  logic                  i_pop,
  output logic [WIDTH-1:0]      o_head_data,
  output logic                  o_head_valid,
  output logic [SKID_CNT_W-1:0] o_cnt
);

  localparam logic [SKID_CNT_W-1:0] CNT_FULL = SKID_CNT_W'(SKID_DEPTH);
  localparam logic [SKID_CNT_W-1:0] CNT_ONE  = SKID_CNT_W'(1);

  logic [WIDTH-1:0]      r_mem [SKID_DEPTH];
  logic                  r_rd_ptr;
  logic                  r_wr_ptr;
  logic [SKID_CNT_W-1:0] r_cnt;
  logic                  w_push;
  logic                  w_pop;

  always_comb begin
    w_pop  = i_pop && (r_cnt != '0);
    // A push into a full buffer is only legal when the head leaves in the same cycle.
    w_push = i_push && ((r_cnt != CNT_FULL) || w_pop);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_cnt    <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_ONE;
        2'b01:   r_cnt <= r_cnt - CNT_ONE;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_head_data  = r_mem[r_rd_ptr];
  assign o_head_valid = (r_cnt != '0);
  assign o_cnt        = r_cnt;

endmodule

// File: rtl/fifo_burst_reader.sv
// Drains synch_fifo in bursts of up to BURST_LEN beats onto a valid/ready stream.
// Bursts start on a full burst of data, an idle timeout, or a flush request.
module fifo_burst_reader
  import fifo_rd_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH = 32,
  parameter int unsigned FIFO_PTR   = 4,
  parameter int unsigned BURST_LEN  = 4,
  parameter int unsigned TIMEOUT    = 15
) (
  input logic                 i_fifo_clk,
  input logic                 i_rst,
  fifo_burst_reader_if.master bus
);

  localparam int unsigned CNT_W   = cnt_width(BURST_LEN);
  localparam int unsigned TMR_W   = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned AVAIL_W = FIFO_PTR + 1;

  localparam logic [CNT_W-1:0]   BURST_CNT   = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0]   CNT_ONE     = CNT_W'(1);
  localparam logic [AVAIL_W-1:0] BURST_AVAIL = AVAIL_W'(BURST_LEN);
  localparam logic [TMR_W-1:0]   TMR_MAX     = TMR_W'(TIMEOUT);
  localparam logic [TMR_W-1:0]   TMR_ONE     = TMR_W'(1);
  localparam logic [2:0]         SKID_MAX    = 3'(SKID_DEPTH);

  rd_state_e             r_state;
  logic [TMR_W-1:0]      r_timer;
  logic [CNT_W-1:0]      r_issue_left;
  logic [CNT_W-1:0]      r_send_left;
  logic                  r_rd_pending;
  logic                  r_burst_active;

  logic [SKID_CNT_W-1:0] w_buf_cnt;
  logic [FIFO_WIDTH-1:0] w_head_data;
  logic                  w_m_valid;
  logic                  w_m_last;
  logic                  w_pop;
  logic [2:0]            w_occ;
  logic                  w_room;
  logic                  w_rden;
  logic                  w_start;
  logic [CNT_W-1:0]      w_beats;

  rd_skid_buf #(
    .WIDTH (FIFO_WIDTH)
  ) u_skid (
    .i_clk        (i_fifo_clk),
    .i_rst        (i_rst),
    .i_push       (r_rd_pending),
    .i_push_data  (bus.fifo_rddata),
    .i_pop        (w_pop),
    .o_head_data  (w_head_data),
    .o_head_valid (w_m_valid),
    .o_cnt        (w_buf_cnt)
  );

  always_comb begin
    w_pop    = w_m_valid && bus.m_ready;
    w_m_last = w_m_valid && (r_send_left == CNT_ONE);
    // Count the in-flight read as occupied so the skid buffer can never overflow.
    w_occ    = 3'(w_buf_cnt) + 3'(r_rd_pending);
    w_room   = w_occ < (SKID_MAX + 3'(w_pop));
    w_rden   = (r_state == BURST) && !i_rst && !bus.fifo_empty &&
               (r_issue_left != '0) && w_room;
    w_beats  = (bus.fifo_data_avail >= BURST_AVAIL) ? BURST_CNT
                                                    : CNT_W'(bus.fifo_data_avail);
    w_start  = (bus.fifo_data_avail >= BURST_AVAIL) ||
               (bus.flush && !bus.fifo_empty) ||
               ((TIMEOUT != 0) && (r_timer == TMR_MAX) && !bus.fifo_empty);
  end

  always_ff @(posedge i_fifo_clk) begin
    if (i_rst) begin
      r_state        <= IDLE;
      r_timer        <= '0;
      r_issue_left   <= '0;
      r_send_left    <= '0;
      r_rd_pending   <= 1'b0;
      r_burst_active <= 1'b0;
    end else begin
      r_rd_pending <= w_rden;
      unique case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state        <= BURST;
            r_burst_active <= 1'b1;
            r_timer        <= '0;
            r_issue_left   <= w_beats;
            r_send_left    <= w_beats;
          end else if (bus.fifo_empty) begin
            r_timer <= '0;
          end else if (r_timer != TMR_MAX) begin
            r_timer <= r_timer + TMR_ONE;
          end
        end
        BURST: begin
          if (w_rden) begin
            r_issue_left <= r_issue_left - CNT_ONE;
          end
          if (w_pop) begin
            r_send_left <= r_send_left - CNT_ONE;
          end
          if (w_pop && w_m_last) begin
            r_state        <= IDLE;
            r_burst_active <= 1'b0;
          end
        end
        default: begin
          r_state        <= IDLE;
          r_burst_active <= 1'b0;
        end
      endcase
    end
  end

  assign bus.fifo_rden    = w_rden;
  assign bus.m_valid      = w_m_valid;
  assign bus.m_data       = w_head_data;
  assign bus.m_last       = w_m_last;
  assign bus.burst_active = r_burst_active;

  a_skid_no_overflow: assert property (@(posedge i_fifo_clk) disable iff (i_rst)
    (3'(w_buf_cnt) + 3'(r_rd_pending)) <= SKID_MAX);

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Randomised and directed bench for fifo_burst_reader with a behavioural FIFO,
// a burst predictor feeding an expected-beat queue, and a decoupled output monitor.
module tb_fifo_burst_reader;

  localparam int unsigned W   = 32;
  localparam int unsigned PTR = 4;
  localparam int unsigned BL  = 4;
  localparam int unsigned TO  = 15;

  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_burst_reader_if #(.FIFO_WIDTH(W), .FIFO_PTR(PTR)) bus ();

  fifo_burst_reader #(
    .FIFO_WIDTH (W),
    .FIFO_PTR   (PTR),
    .BURST_LEN  (BL),
    .TIMEOUT    (TO)
  ) dut (
    .i_fifo_clk (clk),
    .i_rst      (rst),
    .bus        (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [W-1:0] fifo_q  [$];
  logic [W-1:0] words_q [$];
  beat_t        exp_q   [$];

  logic         wr_en   = 1'b0;
  logic [W-1:0] wr_data = '0;
  logic         rd_s    = 1'b0;
  logic         wr_s    = 1'b0;
  logic [W-1:0] wrd_s   = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural synch_fifo: one-cycle read latency, outputs change only at the clock edge.
  always @(negedge clk) begin
    rd_s  = bus.fifo_rden;
    wr_s  = wr_en;
    wrd_s = wr_data;
  end

  always @(posedge clk) begin
    cyc++;
    if (rd_s) begin
      check("rden_on_nonempty", 64'(fifo_q.size() != 0), 64'd1);
      if (fifo_q.size() != 0) bus.fifo_rddata <= fifo_q.pop_front();
    end
    if (wr_s) begin
      fifo_q.push_back(wrd_s);
      words_q.push_back(wrd_s);
    end
    bus.fifo_empty      <= (fifo_q.size() == 0);
    bus.fifo_data_avail <= (PTR + 1)'(fifo_q.size());
  end

  // Burst predictor: decides from occupancy, flush and idle time when a burst
  // starts and how many words it carries, then queues the expected beats.
  bit busy    = 1'b0;
  int left    = 0;
  int tmr     = 0;
  int rd_cnt  = 0;
  int burst_n = 0;
  int vld_due = -1;
  int rd_due  = -1;
  int p_avail;
  int p_n;

  always @(negedge clk) begin
    if (rst) begin
      busy    = 1'b0;
      left    = 0;
      tmr     = 0;
      vld_due = -1;
      rd_due  = -1;
      exp_q.delete();
      words_q = fifo_q;
    end else begin
      if (cyc == rd_due) check("first_rden_latency", 64'(bus.fifo_rden), 64'd1);
      if (cyc == vld_due) check("first_valid_latency", 64'(bus.m_valid), 64'd1);
      check("burst_active", 64'(bus.burst_active), 64'(busy));
      if (!busy) begin
        check("idle_quiet", 64'({bus.m_valid, bus.fifo_rden}), 64'd0);
        p_avail = int'(bus.fifo_data_avail);
        if (p_avail >= BL || (bus.flush && !bus.fifo_empty) ||
            (TO != 0 && tmr == TO && !bus.fifo_empty)) begin
          p_n = (p_avail < BL) ? p_avail : BL;
          for (int i = 0; i < p_n; i++) begin
            exp_q.push_back('{data: words_q.pop_front(), last: (i == p_n - 1)});
          end
          busy    = 1'b1;
          left    = p_n;
          burst_n = p_n;
          rd_cnt  = 0;
          tmr     = 0;
          rd_due  = cyc + 1;
          vld_due = cyc + 3;
        end else if (bus.fifo_empty) begin
          tmr = 0;
        end else if (tmr < TO) begin
          tmr++;
        end
      end else begin
        if (bus.fifo_rden) rd_cnt++;
        if (bus.m_valid && bus.m_ready) begin
          left--;
          if (left == 0) begin
            busy = 1'b0;
            check("reads_per_burst", 64'(rd_cnt), 64'(burst_n));
          end
        end
      end
    end
  end

  // Output monitor: checks each accepted beat against the expected queue.
  logic [W-1:0] prev_data  = '0;
  logic         prev_last  = 1'b0;
  logic         prev_stall = 1'b0;
  int           pops       = 0;
  beat_t        m_exp;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_hold_valid", 64'(bus.m_valid), 64'd1);
        check("stall_hold_data", 64'(bus.m_data), 64'(prev_data));
        check("stall_hold_last", 64'(bus.m_last), 64'(prev_last));
      end
      if (bus.m_valid && bus.m_ready) begin
        pops++;
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_beat: got data %0h, expected no beat (cycle %0d)",
                   bus.m_data, cyc);
        end else begin
          m_exp = exp_q.pop_front();
          check("beat_data", 64'(bus.m_data), 64'(m_exp.data));
          check("beat_last", 64'(bus.m_last), 64'(m_exp.last));
        end
      end
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_data  = bus.m_data;
      prev_last  = bus.m_last;
    end
  end

  task automatic write_words(input int n, input logic [W-1:0] base);
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_data = base + W'(i);
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      if (!busy && exp_q.size() == 0 && fifo_q.size() == 0 && !wr_s) break;
      tick();
    end
    check(name, 64'(k < budget), 64'd1);
  endtask

  initial begin
    int k;
    int p0;
    logic [3:0] pat;
    bus.flush   = 1'b0;
    bus.m_ready = 1'b1;
    rst         = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("reset_outputs", 64'({bus.m_valid, bus.m_last, bus.fifo_rden, bus.burst_active}),
          64'd0);
    check("reset_m_data", 64'(bus.m_data), 64'd0);
    tick();
    rst = 1'b0;
    repeat (2) tick();

    // Full burst with no backpressure.
    write_words(4, 32'hA0);
    wait_idle("drain_full_burst", 60);

    // Partial burst released by the idle timeout.
    write_words(2, 32'hB0);
    wait_idle("drain_timeout_burst", 80);

    // Backpressure with a repeating ready pattern.
    bus.m_ready = 1'b0;
    write_words(4, 32'hC0);
    for (int i = 0; i < 28; i++) begin
      pat         = 4'(i % 7);
      bus.m_ready = (pat == 0 || pat == 3 || pat == 5 || pat == 6);
      tick();
    end
    bus.m_ready = 1'b1;
    wait_idle("drain_backpressure", 60);

    // Flush with data, then flush with an empty FIFO.
    write_words(3, 32'hD0);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    wait_idle("drain_flush", 60);
    bus.flush = 1'b1;
    repeat (3) tick();
    bus.flush = 1'b0;
    repeat (5) tick();

    // Back-to-back bursts plus a timed-out single.
    write_words(9, 32'hE0);
    wait_idle("drain_nine_words", 120);

    // Reset in the middle of a burst.
    p0 = pops;
    write_words(4, 32'hF0);
    for (k = 0; k < 50 && pops < p0 + 2; k++) tick();
    check("mid_burst_two_pops", 64'(pops >= p0 + 2), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_quiet", 64'({bus.m_valid, bus.fifo_rden, bus.burst_active}), 64'd0);
    repeat (25) tick();
    write_words(1, 32'h5A);
    wait_idle("drain_after_reset", 60);

    // Randomised traffic with random flush and backpressure.
    for (int c = 0; c < 500; c++) begin
      wr_en       = ($urandom_range(0, 99) < 35) && (fifo_q.size() < 13);
      wr_data     = $urandom();
      bus.flush   = ($urandom_range(0, 99) < 4);
      bus.m_ready = ($urandom_range(0, 99) < 70);
      tick();
    end
    wr_en       = 1'b0;
    bus.flush   = 1'b0;
    bus.m_ready = 1'b1;
    wait_idle("drain_random", 200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
